loop_group_scheduler: RTL and testbench

// Time-slices the shared loop-iteration FSM between up to NUM_GROUPS loop groups of one compute block.

---
 rtl/loop_group_scheduler_pkg.sv | 14 +
 rtl/rr_next_group.sv | 28 ++
 rtl/loop_group_scheduler.sv | 117 +++++++++++
 tb/tb_loop_group_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_group_scheduler_pkg.sv
// Shared types and defaults for the loop-group scheduler.
package loop_group_scheduler_pkg;

    localparam int unsigned GROUP_ID_W_DEFAULT = 2;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StRun,
        StSwitch,
        StFinish
    } sched_state_t;

endpackage

// File: rtl/rr_next_group.sv
// Round-robin picker: first pending group strictly after cur, wrapping modulo NUM_GROUPS.
module rr_next_group
    import loop_group_scheduler_pkg::*;
#(
    parameter int unsigned GROUP_ID_W = GROUP_ID_W_DEFAULT,
    parameter int unsigned NUM_GROUPS = 1 << GROUP_ID_W
) (
    input  logic [NUM_GROUPS-1:0] pending,
    input  logic [GROUP_ID_W-1:0] cur,
    output logic [GROUP_ID_W-1:0] next_id,
    output logic                  any_other_pending
);

    always_comb begin
        int unsigned j;
        next_id           = cur;
        any_other_pending = 1'b0;
        // Scan farthest-first so the nearest pending group is the last one written.
        for (int unsigned k = NUM_GROUPS - 1; k >= 1; k--) begin
            j = (int'(cur) + k) % NUM_GROUPS;
            if (pending[j[GROUP_ID_W-1:0]]) begin
                next_id           = j[GROUP_ID_W-1:0];
                any_other_pending = 1'b1;
            end
        end
    end

endmodule

// File: rtl/loop_group_scheduler.sv
// Time-slices the shared loop-iteration FSM between loop groups with round-robin preemption.
module loop_group_scheduler
    import loop_group_scheduler_pkg::*;
#(
    parameter int unsigned GROUP_ID_W = GROUP_ID_W_DEFAULT,
    parameter int unsigned NUM_GROUPS = 1 << GROUP_ID_W,
    parameter int unsigned QUANTUM_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_quantum_v,
    input  logic [QUANTUM_W-1:0]  cfg_quantum,
    input  logic                  block_start,
    input  logic [NUM_GROUPS-1:0] group_en,
    input  logic                  ext_stall,
    input  logic                  fsm_done,
    output logic                  fsm_start,
    output logic                  fsm_stall,
    output logic [GROUP_ID_W-1:0] loop_group_id,
    output logic [NUM_GROUPS-1:0] group_done,
    output logic                  block_done,
    output logic                  busy
);

    sched_state_t          state_q;
    logic [NUM_GROUPS-1:0] pending_q;
    logic [QUANTUM_W-1:0]  qcnt_q;
    logic [QUANTUM_W-1:0]  quantum_q;
    logic [GROUP_ID_W-1:0] gid_q;
    logic [NUM_GROUPS-1:0] group_done_q;
    logic [GROUP_ID_W-1:0] first_id;
    logic [GROUP_ID_W-1:0] next_id;
    logic                  any_other;
    logic                  slice_end;

    rr_next_group #(
        .GROUP_ID_W(GROUP_ID_W),
        .NUM_GROUPS(NUM_GROUPS)
    ) u_rr (
        .pending          (pending_q),
        .cur              (gid_q),
        .next_id          (next_id),
        .any_other_pending(any_other)
    );

    always_comb begin
        first_id = '0;
        for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
            if (group_en[i]) first_id = GROUP_ID_W'(i);
        end
    end

    assign slice_end = (quantum_q != '0) && (qcnt_q == quantum_q - QUANTUM_W'(1)) && !ext_stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            pending_q    <= '0;
            qcnt_q       <= '0;
            quantum_q    <= '0;
            gid_q        <= '0;
            group_done_q <= '0;
        end else begin
            if (cfg_quantum_v) quantum_q <= cfg_quantum;
            group_done_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (block_start) begin
                        if (group_en != '0) begin
                            pending_q <= group_en;
                            gid_q     <= first_id;
                            state_q   <= StLaunch;
                        end else begin
                            state_q <= StFinish;
                        end
                    end
                end
                StLaunch, StSwitch: begin
                    qcnt_q  <= '0;
                    state_q <= StRun;
                end
                StRun: begin
                    if (!ext_stall) qcnt_q <= qcnt_q + QUANTUM_W'(1);
                    // Completion takes priority over a coincident quantum expiry.
                    if (fsm_done) begin
                        group_done_q      <= NUM_GROUPS'(1) << gid_q;
                        pending_q[gid_q]  <= 1'b0;
                        if (any_other) begin
                            gid_q   <= next_id;
                            state_q <= StSwitch;
                        end else begin
                            state_q <= StFinish;
                        end
                    end else if (slice_end) begin
                        if (any_other) begin
                            gid_q   <= next_id;
                            state_q <= StSwitch;
                        end else begin
                            qcnt_q <= '0;
                        end
                    end
                end
                StFinish: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    assign fsm_start     = (state_q == StLaunch);
    assign fsm_stall     = (state_q == StLaunch) || (state_q == StSwitch) ||
                           ((state_q == StRun) && ext_stall);
    assign loop_group_id = gid_q;
    assign group_done    = group_done_q;
    assign block_done    = (state_q == StFinish);
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_loop_group_scheduler.sv
// Directed scenarios plus random traffic, checked each cycle against a slice-budget model.
module tb_loop_group_scheduler;

    localparam int GW = 2;
    localparam int NG = 4;
    localparam int QW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_quantum_v;
    logic [QW-1:0] cfg_quantum;
    logic          block_start;
    logic [NG-1:0] group_en;
    logic          ext_stall;
    logic          fsm_done;
    logic          fsm_start;
    logic          fsm_stall;
    logic [GW-1:0] loop_group_id;
    logic [NG-1:0] group_done;
    logic          block_done;
    logic          busy;

    always #5 clk = ~clk;

    loop_group_scheduler #(
        .GROUP_ID_W(GW),
        .NUM_GROUPS(NG),
        .QUANTUM_W (QW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_quantum_v(cfg_quantum_v),
        .cfg_quantum  (cfg_quantum),
        .block_start  (block_start),
        .group_en     (group_en),
        .ext_stall    (ext_stall),
        .fsm_done     (fsm_done),
        .fsm_start    (fsm_start),
        .fsm_stall    (fsm_stall),
        .loop_group_id(loop_group_id),
        .group_done   (group_done),
        .block_done   (block_done),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a block is active; the loop FSM is either being handed a group (launching or
    // resuming after a hand-over) or executing, and a slice ends after m_quant unstalled cycles.
    bit          m_active;
    bit          m_launching;
    bit          m_resuming;
    bit          m_closing;
    int          m_cur;
    bit [NG-1:0] m_left;
    bit [NG-1:0] m_gd;
    int          m_used;
    int          m_quant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_after(input int c, input bit [NG-1:0] left);
        for (int k = 1; k < NG; k++) begin
            if (left[(c + k) % NG]) return (c + k) % NG;
        end
        return -1;
    endfunction

    function automatic void model_step();
        bit executing;
        int nx;
        executing = m_active && !m_launching && !m_resuming && !m_closing;
        if (!reset) begin
            m_active = 0; m_launching = 0; m_resuming = 0; m_closing = 0;
            m_cur = 0; m_left = '0; m_gd = '0; m_used = 0; m_quant = 0;
            return;
        end
        m_gd = '0;
        if (!m_active) begin
            if (block_start) begin
                m_active = 1;
                if (group_en != '0) begin
                    m_left = group_en;
                    for (int i = NG - 1; i >= 0; i--) if (group_en[i]) m_cur = i;
                    m_launching = 1;
                end else begin
                    m_closing = 1;
                end
            end
        end else if (m_closing) begin
            m_active = 0;
            m_closing = 0;
        end else if (!executing) begin
            m_launching = 0;
            m_resuming = 0;
            m_used = 0;
        end else begin
            m_left_done_or_slice(nx);
        end
        if (cfg_quantum_v) m_quant = int'(cfg_quantum);
    endfunction

    function automatic void m_left_done_or_slice(output int nx);
        if (fsm_done) begin
            m_gd[m_cur] = 1'b1;
            m_left[m_cur] = 1'b0;
            nx = next_after(m_cur, m_left);
            if (nx >= 0) begin
                m_cur = nx;
                m_resuming = 1;
            end else begin
                m_closing = 1;
            end
        end else begin
            nx = next_after(m_cur, m_left);
            if (!ext_stall) begin
                m_used = (m_used + 1) % 256;
                if (m_quant != 0 && m_used == m_quant) begin
                    if (nx >= 0) begin
                        m_cur = nx;
                        m_resuming = 1;
                    end else begin
                        m_used = 0;
                    end
                end
            end
        end
    endfunction

    // Compare outputs for the current cycle, then advance DUT and model by one edge.
    task automatic cycle();
        bit executing;
        #1;
        executing = m_active && !m_launching && !m_resuming && !m_closing;
        chk("fsm_start", fsm_start, m_launching);
        chk("fsm_stall", fsm_stall, m_launching || m_resuming || (executing && ext_stall));
        chk("loop_group_id", loop_group_id, m_cur);
        chk("group_done", group_done, m_gd);
        chk("block_done", block_done, m_closing);
        chk("busy", busy, m_active);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_quantum(input int q);
        cfg_quantum_v = 1'b1;
        cfg_quantum   = QW'(q);
        cycle();
        cfg_quantum_v = 1'b0;
    endtask

    task automatic start_block(input logic [NG-1:0] en);
        block_start = 1'b1;
        group_en    = en;
        cycle();
        block_start = 1'b0;
        group_en    = '0;
    endtask

    initial begin
        int rr_ids [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 3, 3, 3, 3, 0};
        int rr_stall[13] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};

        reset = 1'b0; cfg_quantum_v = 1'b0; cfg_quantum = '0; block_start = 1'b0;
        group_en = '0; ext_stall = 1'b0; fsm_done = 1'b0;
        model_step();
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b1;
        #1;
        chk("reset_outputs", {fsm_start, fsm_stall, loop_group_id, group_done, block_done, busy}, 0);

        // Single group
        set_quantum(4);
        start_block(4'b0001);
        chk("single_start", fsm_start, 1'b1);
        repeat (8) cycle();
        chk("single_no_switch", loop_group_id, 0);
        fsm_done = 1'b1;
        cycle();
        fsm_done = 1'b0;
        #1;
        chk("single_gdone", group_done, 4'b0001);
        chk("single_bdone", block_done, 1'b1);
        repeat (2) cycle();

        // Round-robin 0,1,3,0 with 3-cycle slices
        set_quantum(3);
        start_block(4'b1011);
        for (int c = 0; c < 13; c++) begin
            #1;
            chk("rr_id", loop_group_id, rr_ids[c]);
            chk("rr_stall", fsm_stall, rr_stall[c]);
            cycle();
        end
        fsm_done = 1'b1;
        repeat (6) cycle();
        fsm_done = 1'b0;
        repeat (2) cycle();

        // Stall freezes the slice counter
        start_block(4'b0011);
        cycle();
        cycle();
        ext_stall = 1'b1;
        repeat (5) cycle();
        #1;
        chk("stall_hold_id", loop_group_id, 0);
        ext_stall = 1'b0;
        repeat (2) cycle();
        #1;
        chk("stall_switch_id", loop_group_id, 1);
        chk("stall_switch_stall", fsm_stall, 1'b1);
        cycle();

        // Reset during RUN aborts silently
        reset = 1'b0;
        cycle();
        #1;
        chk("abort_outputs", {fsm_start, fsm_stall, loop_group_id, group_done, block_done, busy}, 0);
        reset = 1'b1;
        cycle();

        // fsm_done coincides with quantum expiry of group 1
        set_quantum(2);
        start_block(4'b0110);
        cycle();
        cycle();
        fsm_done = 1'b1;
        cycle();
        fsm_done = 1'b0;
        #1;
        chk("simul_gdone", group_done, 4'b0010);
        chk("simul_next", loop_group_id, 2);
        repeat (7) cycle();
        chk("simul_no_reselect", loop_group_id, 2);
        fsm_done = 1'b1;
        cycle();
        fsm_done = 1'b0;
        repeat (2) cycle();

        // Quantum 0 never preempts
        set_quantum(0);
        start_block(4'b0011);
        repeat (20) cycle();
        chk("q0_still_g0", loop_group_id, 0);
        fsm_done = 1'b1;
        cycle();
        fsm_done = 1'b0;
        #1;
        chk("q0_then_g1", loop_group_id, 1);
        cycle();
        fsm_done = 1'b1;
        cycle();
        fsm_done = 1'b0;
        cycle();

        // Empty block
        start_block(4'b0000);
        #1;
        chk("empty_bdone", block_done, 1'b1);
        chk("empty_no_start", fsm_start, 1'b0);
        repeat (2) cycle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom % 400) != 0;
            cfg_quantum_v = ($urandom % 40) == 0;
            cfg_quantum   = QW'($urandom % 6);
            block_start   = ($urandom % 4) == 0;
            group_en      = NG'($urandom);
            ext_stall     = ($urandom % 4) == 0;
            fsm_done      = ($urandom % 7) == 0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
